conv_stream_engine: RTL and testbench

Parametrised streaming convolution engine for the CNN datapath: accepts a raster-order pixel stream, builds a KS×KS sliding window with internal line buffers, and computes CH output channels per window with signed weights, bias, saturation and optional ReLU. Weights and biases are loaded serially through a config port and retained across frames. It is the generalised successor of the fixed 28×28, 5×5, 3-channel convolution stage and sits between the input image stream and the pooling stage.

---
 rtl/conv_stream_if.sv | 27 ++
 rtl/conv_stream_engine.sv | 168 ++++++++++++++++
 tb/tb_conv_stream_engine.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_stream_if.sv
// rtl/conv_stream_if.sv - coefficient config, pixel stream and result stream bundle for conv_stream_engine
interface conv_stream_if #(
  parameter int DATA_BIT = 8,
  parameter int CH       = 3,
  parameter int OUT_BIT  = 12
);
  logic                  cfg_start;
  logic                  cfg_valid;
  logic [7:0]            cfg_data;
  logic                  cfg_done;
  logic                  in_valid;
  logic [DATA_BIT-1:0]   in_data;
  logic                  in_ready;
  logic [CH*OUT_BIT-1:0] conv_out;
  logic                  out_valid;
  logic                  frame_done;

  modport master (
    output cfg_start, cfg_valid, cfg_data, in_valid, in_data,
    input  cfg_done, in_ready, conv_out, out_valid, frame_done
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, in_valid, in_data,
    output cfg_done, in_ready, conv_out, out_valid, frame_done
  );
endinterface

// File: rtl/conv_stream_engine.sv
// rtl/conv_stream_engine.sv - streaming KSxKS multi-channel convolution with line buffers
// Two-stage datapath: registered products, then bias/sum/saturate into conv_out.
module conv_stream_engine #(
  parameter int WIDTH      = 28,
  parameter int HEIGHT     = 28,
  parameter int KS         = 5,
  parameter int CH         = 3,
  parameter int DATA_BIT   = 8,
  parameter int WEIGHT_BIT = 4,
  parameter int BIAS_BIT   = 8,
  parameter int OUT_BIT    = 12,
  parameter int RELU       = 0
) (
  input logic          clk,
  input logic          rst,
  conv_stream_if.slave bus
);
  localparam int NTAP     = KS * KS;
  localparam int NW       = CH * NTAP;
  localparam int NCFG     = NW + CH;
  localparam int PROD_BIT = DATA_BIT + WEIGHT_BIT + 1;
  localparam int ACC_BIT  = DATA_BIT + WEIGHT_BIT + 6;
  localparam int CW       = $clog2(WIDTH);
  localparam int RW       = $clog2(HEIGHT);
  localparam int LW       = $clog2(NCFG + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic signed [ACC_BIT-1:0] SAT_HI = ACC_BIT'((1 << (OUT_BIT - 1)) - 1);
  localparam logic signed [ACC_BIT-1:0] SAT_LO = ACC_BIT'(-(1 << (OUT_BIT - 1)));

  typedef enum logic [1:0] {IDLE, LOAD, READY, RUN} state_t;
  state_t state_q, state_d;

  logic [LW-1:0]          load_cnt_q;
  logic                   cfg_done_q;
  logic [CW-1:0]          col_q;
  logic [RW-1:0]          row_q;
  logic                   p_valid_q, p_last_q;
  logic                   out_valid_q, frame_done_q;
  logic [CH*OUT_BIT-1:0]  conv_out_q, res_d;

  logic signed [WEIGHT_BIT-1:0] weight_q [NW];
  logic signed [BIAS_BIT-1:0]   bias_q   [CH];
  logic [DATA_BIT-1:0]          lb_q     [KS-1][WIDTH];
  logic [DATA_BIT-1:0]          win_q    [KS][KS];
  logic [DATA_BIT-1:0]          win_d    [KS][KS];
  logic [DATA_BIT-1:0]          col_vec  [KS];
  logic signed [PROD_BIT-1:0]   prod_q   [CH][NTAP];
  logic signed [PROD_BIT-1:0]   prod_d   [CH][NTAP];
  logic signed [ACC_BIT-1:0]    acc;
  logic [OUT_BIT-1:0]           sat;

  logic in_ready, accept, cfg_go, load_wr, cfg_last, last_px, win_hit;

  assign in_ready = (state_q == READY) || (state_q == RUN);
  assign accept   = bus.in_valid && in_ready;
  // A reload request during a frame is ignored; the frame must finish first.
  assign cfg_go   = bus.cfg_start && (state_q != RUN);
  assign load_wr  = (state_q == LOAD) && bus.cfg_valid && !bus.cfg_start;
  assign cfg_last = load_wr && (load_cnt_q == LW'(NCFG - 1));
  assign last_px  = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign win_hit  = accept && (row_q >= RW'(KS - 1)) && (col_q >= CW'(KS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cfg_start) state_d = LOAD;
      LOAD:    if (cfg_last) state_d = READY;
      READY: begin
        if (bus.cfg_start) state_d = LOAD;
        else if (accept && !last_px) state_d = RUN;
      end
      RUN:     if (accept && last_px) state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      load_cnt_q   <= '0;
      cfg_done_q   <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      p_valid_q    <= 1'b0;
      p_last_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      conv_out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_go) begin
        load_cnt_q <= '0;
        cfg_done_q <= 1'b0;
      end else if (load_wr) begin
        load_cnt_q <= load_cnt_q + LW'(1);
        if (cfg_last) cfg_done_q <= 1'b1;
      end
      if (cfg_go) begin
        col_q <= '0;
        row_q <= '0;
      end else if (accept) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= last_px ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      p_valid_q    <= win_hit;
      p_last_q     <= accept && last_px;
      out_valid_q  <= p_valid_q;
      frame_done_q <= p_last_q;
      if (p_valid_q) conv_out_q <= res_d;
    end
  end

  // Products are formed from the next window so a result needs only two register stages.
  always_comb begin
    for (int r = 0; r < KS - 1; r++) col_vec[r] = lb_q[r][col_q];
    col_vec[KS-1] = bus.in_data;
    for (int r = 0; r < KS; r++) begin
      for (int c = 0; c < KS - 1; c++) win_d[r][c] = win_q[r][c+1];
      win_d[r][KS-1] = col_vec[r];
    end
    for (int ch = 0; ch < CH; ch++) begin
      for (int t = 0; t < NTAP; t++) begin
        prod_d[ch][t] = PROD_BIT'($signed({1'b0, win_d[t / KS][t % KS]}))
                      * PROD_BIT'(weight_q[ch*NTAP + t]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_wr) begin
      for (int i = 0; i < NW; i++)
        if (load_cnt_q == LW'(i)) weight_q[i] <= bus.cfg_data[WEIGHT_BIT-1:0];
      for (int i = 0; i < CH; i++)
        if (load_cnt_q == LW'(NW + i)) bias_q[i] <= bus.cfg_data[BIAS_BIT-1:0];
    end
    if (accept) begin
      for (int r = 0; r < KS - 1; r++) lb_q[r][col_q] <= col_vec[r+1];
      win_q  <= win_d;
      prod_q <= prod_d;
    end
  end

  always_comb begin
    res_d = '0;
    acc   = '0;
    sat   = '0;
    for (int ch = 0; ch < CH; ch++) begin
      acc = ACC_BIT'(bias_q[ch]);
      for (int t = 0; t < NTAP; t++) acc = acc + ACC_BIT'(prod_q[ch][t]);
      if (acc > SAT_HI)      sat = SAT_HI[OUT_BIT-1:0];
      else if (acc < SAT_LO) sat = SAT_LO[OUT_BIT-1:0];
      else                   sat = acc[OUT_BIT-1:0];
      if (RELU != 0 && sat[OUT_BIT-1]) sat = '0;
      res_d[ch*OUT_BIT +: OUT_BIT] = sat;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.cfg_done   = cfg_done_q;
  assign bus.conv_out   = conv_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_stream_engine.sv
// tb/tb_conv_stream_engine.sv - table-driven self-checking bench for conv_stream_engine
module tb_conv_stream_engine;
  logic clk;
  logic rst;

  conv_stream_if #(.DATA_BIT(8), .CH(2), .OUT_BIT(12)) ia ();
  conv_stream_if #(.DATA_BIT(8), .CH(1), .OUT_BIT(12)) ib ();
  conv_stream_if #(.DATA_BIT(8), .CH(1), .OUT_BIT(12)) ic ();

  conv_stream_engine #(.WIDTH(8), .HEIGHT(8), .KS(3), .CH(2), .DATA_BIT(8), .WEIGHT_BIT(4),
                       .BIAS_BIT(8), .OUT_BIT(12), .RELU(0))
    u_a (.clk(clk), .rst(rst), .bus(ia));
  conv_stream_engine #(.WIDTH(6), .HEIGHT(6), .KS(5), .CH(1), .DATA_BIT(8), .WEIGHT_BIT(4),
                       .BIAS_BIT(8), .OUT_BIT(12), .RELU(0))
    u_b (.clk(clk), .rst(rst), .bus(ib));
  conv_stream_engine #(.WIDTH(6), .HEIGHT(6), .KS(5), .CH(1), .DATA_BIT(8), .WEIGHT_BIT(4),
                       .BIAS_BIT(8), .OUT_BIT(12), .RELU(1))
    u_c (.clk(clk), .rst(rst), .bus(ic));

  assign ic.cfg_start = ib.cfg_start;
  assign ic.cfg_valid = ib.cfg_valid;
  assign ic.cfg_data  = ib.cfg_data;
  assign ic.in_valid  = ib.in_valid;
  assign ic.in_data   = ib.in_data;

  typedef struct {
    bit load; int mode; int b0; int b1; bit ramp; bit gaps;
    int frames; int exp_cnt; int exp0; int exp1; bit chk_lat;
  } vec_t;
  vec_t vecs [4];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, acc_n = 0, acc18 = 0, first_cyc = 0, fd_a = 0, fd_bad = 0;
  logic [23:0] res_a [$];
  logic [11:0] res_b [$];
  logic [11:0] res_c [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ia.in_valid && ia.in_ready) begin
      if (acc_n == 18) acc18 = cyc;
      acc_n++;
    end
    if (ia.out_valid) begin
      if (res_a.size() == 0) first_cyc = cyc;
      res_a.push_back(ia.conv_out);
    end
    if (ia.frame_done) begin
      fd_a++;
      if (!ia.out_valid || (res_a.size() % 36) != 0) fd_bad++;
    end
    if (ib.out_valid) res_b.push_back(ib.conv_out);
    if (ic.out_valid) res_c.push_back(ic.conv_out);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pix(input bit ramp, input int r, input int c);
    return ramp ? r * 8 + c : 1;
  endfunction

  // mode 0: all taps 1; mode 1: ch0 centre tap only, ch1 all taps -1
  function automatic int wgt(input int mode, input int ch, input int i, input int j);
    if (mode == 0) return 1;
    if (ch == 0) return (i == 1 && j == 1) ? 1 : 0;
    return -1;
  endfunction

  function automatic int model(input bit ramp, input int mode, input int ch, input int bias,
                               input int r0, input int c0);
    int s;
    s = bias;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += pix(ramp, r0 + i, c0 + j) * wgt(mode, ch, i, j);
    if (s > 2047) s = 2047;
    if (s < -2048) s = -2048;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input int mode, input int b0, input int b1);
    ia.cfg_start = 1'b1;
    tick();
    ia.cfg_start = 1'b0;
    check("load_a_ready_low", ia.in_ready, 0);
    check("load_a_done_low", ia.cfg_done, 0);
    for (int ch = 0; ch < 2; ch++)
      for (int t = 0; t < 9; t++) begin
        ia.cfg_valid = 1'b1;
        ia.cfg_data  = 8'(wgt(mode, ch, t / 3, t % 3));
        tick();
      end
    ia.cfg_data = 8'(b0);
    tick();
    ia.cfg_data = 8'(b1);
    tick();
    ia.cfg_valid = 1'b0;
    check("load_a_ready_high", ia.in_ready, 1);
    check("load_a_done_high", ia.cfg_done, 1);
  endtask

  task automatic send_a(input bit ramp, input bit gaps);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int g;
        g = 0;
        while (gaps && g < 3 && $urandom_range(0, 1) == 1) begin
          ia.in_valid = 1'b0;
          tick();
          g++;
        end
        ia.in_valid = 1'b1;
        ia.in_data  = 8'(pix(ramp, r, c));
        tick();
      end
    ia.in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k, mm, f0, f1, w;
    logic [23:0] x;
    if (v.load) load_a(v.mode, v.b0, v.b1);
    check($sformatf("v%0d_in_ready", idx), ia.in_ready, 1);
    res_a.delete();
    fd_a = 0; fd_bad = 0; acc_n = 0; acc18 = -100; first_cyc = -1;
    for (int f = 0; f < v.frames; f++) send_a(v.ramp, v.gaps);
    k = 0;
    while (fd_a < v.frames && k < 300) begin
      tick();
      k++;
    end
    check($sformatf("v%0d_drain", idx), (fd_a >= v.frames) ? 1 : 0, 1);
    repeat (4) tick();
    check($sformatf("v%0d_count", idx), res_a.size(), v.exp_cnt);
    check($sformatf("v%0d_frame_done", idx), fd_a, v.frames);
    check($sformatf("v%0d_fd_align", idx), fd_bad, 0);
    f0 = -99999; f1 = -99999;
    if (res_a.size() > 0) begin
      x  = res_a[0];
      f0 = $signed(x[11:0]);
      f1 = $signed(x[23:12]);
    end
    check($sformatf("v%0d_first_ch0", idx), f0, v.exp0);
    check($sformatf("v%0d_first_ch1", idx), f1, v.exp1);
    mm = 0;
    for (int i = 0; i < res_a.size(); i++) begin
      x = res_a[i];
      w = i % 36;
      if ($signed(x[11:0]) != model(v.ramp, v.mode, 0, v.b0, w / 6, w % 6)) mm++;
      if ($signed(x[23:12]) != model(v.ramp, v.mode, 1, v.b1, w / 6, w % 6)) mm++;
    end
    check($sformatf("v%0d_model_mismatches", idx), mm, 0);
    if (v.chk_lat) check($sformatf("v%0d_latency", idx), first_cyc - acc18, 2);
  endtask

  task automatic run_b(input int w, input int b, input int exp_b, input int exp_c, input string nm);
    int mb, mc;
    ib.cfg_start = 1'b1;
    tick();
    ib.cfg_start = 1'b0;
    for (int t = 0; t < 26; t++) begin
      ib.cfg_valid = 1'b1;
      ib.cfg_data  = (t < 25) ? 8'(w) : 8'(b);
      tick();
    end
    ib.cfg_valid = 1'b0;
    check({nm, "_cfg_done"}, ib.cfg_done, 1);
    res_b.delete();
    res_c.delete();
    for (int p = 0; p < 36; p++) begin
      ib.in_valid = 1'b1;
      ib.in_data  = 8'd255;
      tick();
    end
    ib.in_valid = 1'b0;
    repeat (6) tick();
    check({nm, "_count_relu0"}, res_b.size(), 4);
    check({nm, "_count_relu1"}, res_c.size(), 4);
    mb = 0; mc = 0;
    foreach (res_b[i]) if ($signed(res_b[i]) != exp_b) mb++;
    foreach (res_c[i]) if ($signed(res_c[i]) != exp_c) mc++;
    check({nm, "_value_relu0"}, mb, 0);
    check({nm, "_value_relu1"}, mc, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 0, 0,  5, 1'b0, 1'b0, 1, 36, 9,  14, 1'b0};
    vecs[1] = '{1'b1, 1, 0, -3, 1'b1, 1'b0, 1, 36, 9, -84, 1'b1};
    vecs[2] = '{1'b0, 1, 0, -3, 1'b1, 1'b1, 1, 36, 9, -84, 1'b0};
    vecs[3] = '{1'b0, 1, 0, -3, 1'b1, 1'b0, 2, 72, 9, -84, 1'b0};

    rst = 1'b0;
    ia.cfg_start = 1'b0; ia.cfg_valid = 1'b0; ia.cfg_data = '0;
    ia.in_valid  = 1'b0; ia.in_data   = '0;
    ib.cfg_start = 1'b0; ib.cfg_valid = 1'b0; ib.cfg_data = '0;
    ib.in_valid  = 1'b0; ib.in_data   = '0;
    repeat (3) tick();
    check("reset_out_valid", ia.out_valid, 0);
    check("reset_conv_out", ia.conv_out, 0);
    check("reset_frame_done", ia.frame_done, 0);
    check("reset_cfg_done", ia.cfg_done, 0);
    check("reset_in_ready", ia.in_ready, 0);
    rst = 1'b1;
    tick();

    run_b(7, 127, 2047, 2047, "sat_pos");
    run_b(-8, -128, -2048, 0, "sat_neg");

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    load_a(0, 0, 5);
    for (int p = 0; p < 30; p++) begin
      ia.in_valid = 1'b1;
      ia.in_data  = 8'd1;
      tick();
    end
    check("mid_frame_conv_out", ia.conv_out, longint'({12'd14, 12'd9}));
    #2 rst = 1'b0;
    #1;
    check("async_rst_conv_out", ia.conv_out, 0);
    check("async_rst_out_valid", ia.out_valid, 0);
    check("async_rst_frame_done", ia.frame_done, 0);
    check("async_rst_cfg_done", ia.cfg_done, 0);
    check("async_rst_in_ready", ia.in_ready, 0);
    ia.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    run_vec(vecs[0], 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
